// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension unit: mode encoding used by
// the decode stage and carried alongside each extended operand.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        IMM_SEXT   = 2'd0,
        IMM_ZEXT   = 2'd1,
        IMM_LUI    = 2'd2,
        IMM_BRANCH = 2'd3
    } imm_mode_t;

    localparam int unsigned IMM_FIFO_DEPTH = 2;

endpackage

// File: rtl/imm_ext_core.sv
// Purely combinational extension of an IN_W-bit immediate to OUT_W bits
// according to the selected mode.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  imm_mode_t          mode,
    input  logic [IN_W-1:0]    imm,
    output logic [OUT_W-1:0]   data
);

    logic [OUT_W-1:0] sext_val;
    logic [OUT_W-1:0] zext_val;
    logic [OUT_W-1:0] lui_val;
    logic [OUT_W-1:0] branch_val;

    assign sext_val   = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    assign zext_val   = {{(OUT_W-IN_W){1'b0}}, imm};
    assign lui_val    = {imm, {(OUT_W-IN_W){1'b0}}};
    // Word-aligned branch offset: top two sign bits fall off the end.
    assign branch_val = {sext_val[OUT_W-3:0], 2'b00};

    always_comb begin
        data = sext_val;
        case (mode)
            IMM_SEXT:   data = sext_val;
            IMM_ZEXT:   data = zext_val;
            IMM_LUI:    data = lui_val;
            IMM_BRANCH: data = branch_val;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate-extension stage: extension core followed by a 2-entry
// register FIFO with valid/ready on both sides and a synchronous flush.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_imm,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [1:0]         out_mode
);

    if (IN_W < 2 || IN_W > OUT_W - 2) begin : g_bad_params
        $error("imm_extend_pipe: IN_W must lie in 2..OUT_W-2");
    end

    logic [OUT_W-1:0] ext_data;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .mode (imm_mode_t'(in_mode)),
        .imm  (in_imm),
        .data (ext_data)
    );

    logic [OUT_W-1:0] data_q [IMM_FIFO_DEPTH];
    logic [OUT_W-1:0] data_d [IMM_FIFO_DEPTH];
    imm_mode_t        mode_q [IMM_FIFO_DEPTH];
    imm_mode_t        mode_d [IMM_FIFO_DEPTH];
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             push;
    logic             pop;

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = data_q[head_q];
    assign out_mode  = mode_q[head_q];

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        for (int i = 0; i < IMM_FIFO_DEPTH; i++) begin
            data_d[i] = data_q[i];
            mode_d[i] = mode_q[i];
        end

        if (pop) begin
            head_d = ~head_q;
        end
        if (push) begin
            data_d[tail_q] = ext_data;
            mode_d[tail_q] = imm_mode_t'(in_mode);
            tail_d         = ~tail_q;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // Squash empties the buffer; the stale head value keeps driving out_data.
        if (flush) begin
            count_d = 2'd0;
            tail_d  = head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    for (genvar gi = 0; gi < IMM_FIFO_DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (reset) begin
                data_q[gi] <= '0;
                mode_q[gi] <= IMM_SEXT;
            end else begin
                data_q[gi] <= data_d[gi];
                mode_q[gi] <= mode_d[gi];
            end
        end
    end

endmodule
